// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HUNT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then increment unless already at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping detection, a one-cycle match pulse and a saturating match count.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [PAT_W-1:0]  PAT_ZERO  = {PAT_W{1'b0}};

    state_t              state_q;
    logic [PAT_W-1:0]    pattern_q;
    logic [PAT_W-1:0]    hist_q;
    logic [PAT_W-1:0]    hist_d;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_d;
    logic                match_q;
    logic                armed_q;
    logic                accept_s;
    logic                hit_s;

    // Candidate history/fill for an accepted bit and the detection decision on them.
    always_comb begin
        accept_s = din_valid & ~pat_load & (state_q != S_IDLE);
        hist_d   = {hist_q[PAT_W-2:0], din};
        if (fill_q == FILL_FULL) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + FILL_ONE;
        end
        hit_s = accept_s && (hist_d == pattern_q) && (fill_d == FILL_FULL);
    end

    // Detector FSM: reload has priority over data; a hit either keeps hunting
    // (overlap) or restarts collection from an empty history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pattern_q <= PAT_ZERO;
            hist_q    <= PAT_ZERO;
            fill_q    <= FILL_ZERO;
            match_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            match_q <= 1'b0;
            if (pat_load) begin
                pattern_q <= pat_in;
                hist_q    <= PAT_ZERO;
                fill_q    <= FILL_ZERO;
                state_q   <= S_FILL;
                armed_q   <= 1'b1;
            end else if (accept_s) begin
                if (hit_s) begin
                    match_q <= 1'b1;
                    if (overlap_en) begin
                        hist_q  <= hist_d;
                        fill_q  <= FILL_FULL;
                        state_q <= S_HUNT;
                    end else begin
                        hist_q  <= PAT_ZERO;
                        fill_q  <= FILL_ZERO;
                        state_q <= S_FILL;
                    end
                end else begin
                    hist_q  <= hist_d;
                    fill_q  <= fill_d;
                    state_q <= (fill_d == FILL_FULL) ? S_HUNT : S_FILL;
                end
            end else begin
                state_q <= state_q;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_s),
        .clr   (cnt_clr),
        .cnt   (match_cnt)
    );

    assign match = match_q;
    assign armed = armed_q;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench: hand-built vector table, directed corner sequences and a
// randomized phase checked against a bit-queue reference model.
module tb_seq_detector;

    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          din;
    logic          din_valid;
    logic          pat_load;
    logic [PW-1:0] pat_in;
    logic          overlap_en;
    logic          cnt_clr;
    logic          match8;
    logic [7:0]    cnt8;
    logic          armed8;
    logic          match2;
    logic [1:0]    cnt2;
    logic          armed2;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_detector #(.PAT_W(PW), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
        .cnt_clr(cnt_clr), .match(match8), .match_cnt(cnt8), .armed(armed8)
    );

    seq_detector #(.PAT_W(PW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .overlap_en(overlap_en),
        .cnt_clr(cnt_clr), .match(match2), .match_cnt(cnt2), .armed(armed2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the bits accepted since the last (re)arm, newest at the back.
    bit            m_armed;
    logic [PW-1:0] m_pat;
    bit            m_hist[$];
    bit            m_match;
    int            m_cnt8;
    int            m_cnt2;

    function automatic void model_reset();
        m_armed = 1'b0;
        m_pat   = '0;
        m_hist.delete();
        m_match = 1'b0;
        m_cnt8  = 0;
        m_cnt2  = 0;
    endfunction

    function automatic void model_step(input bit d, input bit v, input bit l,
                                       input logic [PW-1:0] p, input bit o, input bit c);
        bit            hit;
        logic [PW-1:0] word;
        hit     = 1'b0;
        m_match = 1'b0;
        if (l) begin
            m_armed = 1'b1;
            m_pat   = p;
            m_hist.delete();
        end else if (v && m_armed) begin
            m_hist.push_back(d);
            if (m_hist.size() > PW) void'(m_hist.pop_front());
            if (m_hist.size() == PW) begin
                word = '0;
                foreach (m_hist[i]) word[PW-1-i] = m_hist[i];
                hit = (word == m_pat);
            end
            if (hit) begin
                m_match = 1'b1;
                if (!o) m_hist.delete();
            end
        end
        if (c) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one set of inputs, take one rising edge, advance the model, settle.
    task automatic cyc(input bit d, input bit v, input bit l,
                       input logic [PW-1:0] p, input bit o, input bit c);
        din        = d;
        din_valid  = v;
        pat_load   = l;
        pat_in     = p;
        overlap_en = o;
        cnt_clr    = c;
        @(posedge clk);
        model_step(d, v, l, p, o, c);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit            d;
        bit            v;
        bit            l;
        logic [PW-1:0] p;
        bit            o;
        bit            c;
        bit            em;
        int            ec;
        bit            ea;
    } vec_t;

    function automatic vec_t mk(input bit d, input bit v, input bit l, input logic [PW-1:0] p,
                                input bit o, input bit c, input bit em, input int ec, input bit ea);
        vec_t r;
        r.d = d; r.v = v; r.l = l; r.p = p; r.o = o; r.c = c;
        r.em = em; r.ec = ec; r.ea = ea;
        return r;
    endfunction

    vec_t tbl[31];

    initial begin
        int pulses;
        int e8;
        int e2;

        din = 1'b0; din_valid = 1'b0; pat_load = 1'b0; pat_in = '0;
        overlap_en = 1'b0; cnt_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", match8, 0);
        chk("rst_cnt", cnt8, 0);
        chk("rst_armed", armed8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Data before any pattern load is ignored.
        for (int i = 0; i < 4; i++) begin
            cyc((i != 1), 1'b1, 1'b0, 4'b1011, 1'b1, 1'b0);
            chk("idle_match", match8, 0);
            chk("idle_cnt", cnt8, 0);
            chk("idle_armed", armed8, 0);
        end

        //          d     v     l     pat      ov    clr   em    ec  ea
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 1'b1);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        tbl[14] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        tbl[16] = mk(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[19] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[20] = mk(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[21] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        tbl[22] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 1'b1);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[24] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[25] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[26] = mk(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[27] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[28] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[29] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        tbl[30] = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 1'b1);

        for (int i = 0; i < 31; i++) begin
            cyc(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].p, tbl[i].o, tbl[i].c);
            chk($sformatf("tbl%0d_match", i), match8, tbl[i].em);
            chk($sformatf("tbl%0d_match_w2", i), match2, tbl[i].em);
            chk($sformatf("tbl%0d_cnt", i), cnt8, tbl[i].ec);
            chk($sformatf("tbl%0d_cnt_w2", i), cnt2, tbl[i].ec);
            chk($sformatf("tbl%0d_armed", i), armed8, tbl[i].ea);
        end

        // Periodic pattern with overlap: every bit from the 4th on completes a match.
        cyc(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
            if (match8) pulses++;
            e8 = (k >= 4) ? k - 3 : 0;
            e2 = (e8 > 3) ? 3 : e8;
            chk($sformatf("sat%0d_match", k), match2, (k >= 4));
            chk($sformatf("sat%0d_cnt", k), cnt8, e8);
            chk($sformatf("sat%0d_cnt_w2", k), cnt2, e2);
        end
        chk("sat_pulses", pulses, 5);
        cyc(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        chk("clr_on_match_match", match8, 1);
        chk("clr_on_match_cnt", cnt8, 0);
        chk("clr_on_match_cnt_w2", cnt2, 0);

        // Asynchronous reset partway through a pattern, then data without a reload.
        cyc(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc((i != 1) && (i != 5), 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
        chk("pre_rst_cnt", cnt8, 1);
        chk("pre_rst_armed", armed8, 1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_match", match8, 0);
        chk("async_rst_cnt", cnt8, 0);
        chk("async_rst_armed", armed8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc((i != 1), 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
            chk("post_rst_match", match8, 0);
            chk("post_rst_armed", armed8, 0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(1)), ($urandom_range(3) != 0), ($urandom_range(39) == 0),
                4'($urandom), ($urandom_range(3) != 0), ($urandom_range(49) == 0));
            chk("rnd_match", match8, m_match);
            chk("rnd_match_w2", match2, m_match);
            chk("rnd_cnt", cnt8, m_cnt8);
            chk("rnd_cnt_w2", cnt2, m_cnt2);
            chk("rnd_armed", armed8, m_armed);
            chk("rnd_armed_w2", armed2, m_armed);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
